z_seq_driver: RTL
=================

// Module: z_seq_driver
// PURPOSE
//   Stimulus/check end of the serial x/z link. Accepts WIDTH-bit words over a valid/ready
//   handshake and serializes them LSB-first onto x for the downstream 5-state detector.
//   Keeps a cycle-exact shadow copy of that detector, predicts its z output, and flags
//   any disagreement with the z actually returned. Sits between the test/control logic
//   and the detector, driving the detector's x input.
// PARAMETERS
//   WIDTH     8   bits per word (>=2), shifted LSB first
//   IDLE_BIT  0   x level driven whenever no word is shifting
// PORTS
//   clk            in   1      single clock, rising edge
//   reset          in   1      asynchronous, active-high
//   in_data        in   WIDTH  word to send
//   in_valid       in   1      in_data valid
//   in_ready       out  1      1 in IDLE; transfer on in_valid && in_ready at posedge
//   x              out  1      serial bit to the detector
//   z_in           in   1      z returned by the detector
//   chk_en         in   1      1 = compare z_in against the prediction this cycle
//   exp_z          out  1      predicted z (shadow state is D or E)
//   busy           out  1      1 while in SHIFT
//   done           out  1      one-cycle pulse after the last bit of a word
//   mismatch       out  1      sticky; set on the first compare failure
//   mismatch_cnt   out  8      saturating count of compare failures
// BEHAVIOUR
//   Reset (async, immediate): ctl=IDLE, shreg=0, bitcnt=0, shadow=A, x=IDLE_BIT, in_ready=1,
//     busy=0, done=0, mismatch=0, mismatch_cnt=0. Hold reset high across >=1 posedge, so
//     the detector's synchronous reset also takes effect and both copies start in A.
//   Control FSM:
//     IDLE : x=IDLE_BIT; on accept -> shreg<=in_data, bitcnt<=0, go SHIFT.
//     SHIFT: x=shreg[0]; each posedge shreg>>=1, bitcnt++; at the posedge ending bit
//            WIDTH-1 -> IDLE and done=1 for the next cycle only.
//   Timing: accept at edge k -> bit i on x during cycle k+i (i=0..WIDTH-1); done high in
//     cycle k+WIDTH; in_ready high in the same cycle. Back-to-back words are separated by
//     exactly one IDLE_BIT cycle. in_valid while busy is ignored (no accept, no loss of
//     the current word).
//   x is decoded from flops only (state, shreg[0]). No combinational path from any input.
//   Shadow model, updated every posedge from the current x (in IDLE as well):
//     A: x?B:A   B: x?E:B   C: x?B:C   D: x?C:B   E: x?E:D
//     exp_z = (shadow==D)||(shadow==E), combinational from the shadow flops (Moore).
//   Compare, each cycle: fail = chk_en && (z_in != exp_z). On fail, the next posedge sets
//     mismatch=1 (held until reset) and increments mismatch_cnt, saturating at 255.
//   Illegal shadow encodings (5..7) return to A on the next edge; exp_z=0 while illegal.
//   Reset mid-word: the word is dropped, no done pulse, x returns to IDLE_BIT immediately,
//     counters clear.
// TESTING
//   1 Reset hold 2 cycles, release -> in_ready=1, x=0, exp_z=0, mismatch=0, cnt=0.
//   2 WIDTH=8, send 8'h03 at edge k -> x=1,1,0,0,0,0,0,0 in cycles k..k+7; exp_z=1 only in
//     cycles k+2,k+3; done pulses in cycle k+8 only.
//   3 Send 8'h05 with z_in looped from a real detector, chk_en=1 -> exp_z=1 in cycles k+3,
//     k+4; mismatch stays 0.
//   4 Send 8'h03 with z_in tied 0, chk_en=1 -> mismatch rises after the k+2 edge,
//     mismatch_cnt=2 after the word; with chk_en=0 -> both stay 0.
//   5 Words 8'hFF then 8'h00 back-to-back with in_valid held -> one x=0 gap cycle between
//     them; in_valid during SHIFT does not disturb shreg.
//   6 Assert reset at bit 3 of 8'hAA -> x=0 immediately, no done, shadow=A; force 300
//     failures afterwards -> mismatch_cnt holds at 255.

Source files
------------

// File: rtl/z_seq_driver_if.sv
// Word handshake between the test/control logic and z_seq_driver.
//   in_data  : word to serialize (WIDTH bits)
//   in_valid : in_data is valid
//   in_ready : driver is idle and will take the word at the next rising edge
// master = word source, slave = z_seq_driver.
interface z_seq_driver_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready
  );
endinterface

// File: rtl/z_seq_driver.sv
// z_seq_driver
//   Serializes WIDTH-bit words LSB-first onto x for a downstream 5-state detector,
//   runs a cycle-exact shadow of that detector to predict its z output, and flags
//   disagreements between the prediction and the z actually returned.
// Ports
//   clk          : rising-edge clock
//   reset        : asynchronous, active-high
//   in_bus       : word handshake (in_data / in_valid / in_ready), slave side
//   x            : serial bit to the detector (IDLE_BIT when not shifting)
//   z_in         : z returned by the detector
//   chk_en       : compare z_in against exp_z this cycle
//   exp_z        : predicted detector z (shadow in D or E)
//   busy         : a word is being shifted
//   done         : one-cycle pulse in the cycle after the last bit of a word
//   mismatch     : sticky compare-failure flag
//   mismatch_cnt : saturating count of compare failures
module z_seq_driver #(
  parameter int   WIDTH    = 8,
  parameter logic IDLE_BIT = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  z_seq_driver_if.slave       in_bus,
  output logic                x,
  input  logic                z_in,
  input  logic                chk_en,
  output logic                exp_z,
  output logic                busy,
  output logic                done,
  output logic                mismatch,
  output logic [7:0]          mismatch_cnt
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ctl_t;

  // Detector states; 5..7 are unused encodings that recover to SH_A.
  typedef enum logic [2:0] {
    SH_A = 3'd0,
    SH_B = 3'd1,
    SH_C = 3'd2,
    SH_D = 3'd3,
    SH_E = 3'd4
  } shadow_t;

  ctl_t             ctl_reg,      ctl_next;
  logic [WIDTH-1:0] shreg_reg,    shreg_next;
  logic [CW-1:0]    bitcnt_reg,   bitcnt_next;
  logic             done_reg,     done_next;
  shadow_t          shadow_reg,   shadow_next;
  logic             mismatch_reg, mismatch_next;
  logic [7:0]       cnt_reg,      cnt_next;
  logic             fail;

  // x comes straight from flops so the detector sees no combinational input path.
  assign x               = (ctl_reg == SHIFT) ? shreg_reg[0] : IDLE_BIT;
  assign in_bus.in_ready = (ctl_reg == IDLE);
  assign busy            = (ctl_reg == SHIFT);
  assign done            = done_reg;
  assign exp_z           = (shadow_reg == SH_D) || (shadow_reg == SH_E);
  assign mismatch        = mismatch_reg;
  assign mismatch_cnt    = cnt_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctl_reg      <= IDLE;
      shreg_reg    <= '0;
      bitcnt_reg   <= '0;
      done_reg     <= 1'b0;
      shadow_reg   <= SH_A;
      mismatch_reg <= 1'b0;
      cnt_reg      <= 8'd0;
    end else begin
      ctl_reg      <= ctl_next;
      shreg_reg    <= shreg_next;
      bitcnt_reg   <= bitcnt_next;
      done_reg     <= done_next;
      shadow_reg   <= shadow_next;
      mismatch_reg <= mismatch_next;
      cnt_reg      <= cnt_next;
    end
  end

  always_comb begin
    ctl_next      = ctl_reg;
    shreg_next    = shreg_reg;
    bitcnt_next   = bitcnt_reg;
    done_next     = 1'b0;
    shadow_next   = SH_A;
    mismatch_next = mismatch_reg;
    cnt_next      = cnt_reg;
    fail          = chk_en && (z_in != exp_z);

    // Control: load on accept, then shift one bit per edge.
    case (ctl_reg)
      IDLE: begin
        if (in_bus.in_valid) begin
          shreg_next  = in_bus.in_data;
          bitcnt_next = '0;
          ctl_next    = SHIFT;
        end
      end
      SHIFT: begin
        shreg_next  = shreg_reg >> 1;
        bitcnt_next = bitcnt_reg + 1'b1;
        if (bitcnt_reg == LAST_BIT) begin
          bitcnt_next = '0;
          ctl_next    = IDLE;
          done_next   = 1'b1;
        end
      end
      default: begin
        ctl_next = IDLE;
      end
    endcase

    // Shadow detector tracks whatever x is on the wire, idle cycles included.
    case (shadow_reg)
      SH_A:    shadow_next = x ? SH_B : SH_A;
      SH_B:    shadow_next = x ? SH_E : SH_B;
      SH_C:    shadow_next = x ? SH_B : SH_C;
      SH_D:    shadow_next = x ? SH_C : SH_B;
      SH_E:    shadow_next = x ? SH_E : SH_D;
      default: shadow_next = SH_A;
    endcase

    if (fail) begin
      mismatch_next = 1'b1;
      if (cnt_reg != 8'hFF) begin
        cnt_next = cnt_reg + 8'd1;
      end
    end
  end

endmodule
